// File: rtl/mmu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmu_port_arbiter
// Purpose  : Shares the MMU core-side AXI-lite port between the fetch master
//            (read-only) and the load/store master, one whole transaction at
//            a time. Optional macro ARB_RR_EN selects round-robin arbitration
//            instead of fixed priority with a fetch starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
module mmu_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch master
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [1:0]          i_rresp,
    output logic                i_rvalid,
    input  logic                i_rready,
    // load/store master
    input  logic [ADDR_W-1:0]   d_araddr,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [1:0]          d_rresp,
    output logic                d_rvalid,
    input  logic                d_rready,
    input  logic [ADDR_W-1:0]   d_awaddr,
    input  logic                d_awvalid,
    output logic                d_awready,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic                d_wvalid,
    output logic                d_wready,
    output logic [1:0]          d_bresp,
    output logic                d_bvalid,
    input  logic                d_bready,
    // MMU side
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                is_instr,
    input  logic                mmu_exc,
    input  logic [2:0]          mmu_exc_vec,
    output logic                exc_valid,
    output logic                exc_src,
    output logic [2:0]          exc_vec
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_I_AR = 3'd1;
    localparam logic [2:0] S_I_R  = 3'd2;
    localparam logic [2:0] S_D_AR = 3'd3;
    localparam logic [2:0] S_D_R  = 3'd4;
    localparam logic [2:0] S_D_AW = 3'd5;
    localparam logic [2:0] S_D_W  = 3'd6;
    localparam logic [2:0] S_D_B  = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_is_instr;
    logic       r_exc_valid;
    logic       r_exc_src;
    logic [2:0] r_exc_vec;

    logic w_data_req;
    logic w_fetch_win;
    logic w_grant;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_done;

    assign w_data_req = d_arvalid | d_awvalid;
    assign w_grant    = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

`ifdef ARB_RR_EN
    logic r_last_fetch;

    // On a tie, favour whichever master was not granted last.
    assign w_fetch_win = i_arvalid & (~w_data_req | ~r_last_fetch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_fetch <= 1'b0;
        end else if (w_grant) begin
            r_last_fetch <= w_fetch_win;
        end
    end
`else
    localparam int         C_CNT_W = 4;
    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    logic [C_CNT_W-1:0] r_starve_cnt;

    assign w_fetch_win = i_arvalid & (~w_data_req | (r_starve_cnt == C_LIMIT));

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_fetch_win || !i_arvalid) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != C_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        m_araddr  = '0;
        m_arvalid = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        m_rready  = 1'b0;
        i_rdata   = '0;
        i_rresp   = '0;
        i_rvalid  = 1'b0;
        d_rdata   = '0;
        d_rresp   = '0;
        d_rvalid  = 1'b0;
        m_awaddr  = '0;
        m_awvalid = 1'b0;
        d_awready = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wvalid  = 1'b0;
        d_wready  = 1'b0;
        d_bresp   = '0;
        d_bvalid  = 1'b0;
        m_bready  = 1'b0;
        case (r_state)
            S_I_AR: begin
                m_araddr  = i_araddr;
                m_arvalid = i_arvalid;
                i_arready = m_arready;
            end
            S_I_R: begin
                m_araddr  = i_araddr;
                i_rdata   = m_rdata;
                i_rresp   = m_rresp;
                i_rvalid  = m_rvalid;
                m_rready  = i_rready;
            end
            S_D_AR: begin
                m_araddr  = d_araddr;
                m_arvalid = d_arvalid;
                d_arready = m_arready;
            end
            S_D_R: begin
                m_araddr  = d_araddr;
                d_rdata   = m_rdata;
                d_rresp   = m_rresp;
                d_rvalid  = m_rvalid;
                m_rready  = d_rready;
            end
            S_D_AW: begin
                m_awaddr  = d_awaddr;
                m_awvalid = d_awvalid;
                d_awready = m_awready;
                m_wdata   = d_wdata;
                m_wstrb   = d_wstrb;
            end
            S_D_W: begin
                m_awaddr  = d_awaddr;
                m_wdata   = d_wdata;
                m_wstrb   = d_wstrb;
                m_wvalid  = d_wvalid;
                d_wready  = m_wready;
            end
            S_D_B: begin
                m_awaddr  = d_awaddr;
                m_wdata   = d_wdata;
                m_wstrb   = d_wstrb;
                d_bresp   = m_bresp;
                d_bvalid  = m_bvalid;
                m_bready  = d_bready;
            end
            default: ;
        endcase
    end

    assign w_ar_hs = m_arvalid & m_arready;
    assign w_r_hs  = m_rvalid  & m_rready;
    assign w_aw_hs = m_awvalid & m_awready;
    assign w_w_hs  = m_wvalid  & m_wready;
    assign w_b_hs  = m_bvalid  & m_bready;
    assign w_done  = w_r_hs | w_b_hs;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fetch_win) begin
                    w_state_nxt = S_I_AR;
                end else if (d_arvalid) begin
                    w_state_nxt = S_D_AR;
                end else if (d_awvalid) begin
                    w_state_nxt = S_D_AW;
                end
            end
            S_I_AR: if (w_ar_hs) w_state_nxt = S_I_R;
            S_I_R:  if (w_r_hs)  w_state_nxt = S_IDLE;
            S_D_AR: if (w_ar_hs) w_state_nxt = S_D_R;
            S_D_R:  if (w_r_hs)  w_state_nxt = S_IDLE;
            S_D_AW: if (w_aw_hs) w_state_nxt = S_D_W;
            S_D_W:  if (w_w_hs)  w_state_nxt = S_D_B;
            S_D_B:  if (w_b_hs)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // is_instr is derived from the next state so it is already stable when
    // the fetch AR valid is first forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_instr  <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_src   <= 1'b0;
            r_exc_vec   <= 3'b000;
        end else begin
            r_state     <= w_state_nxt;
            r_is_instr  <= (w_state_nxt == S_I_AR) || (w_state_nxt == S_I_R);
            r_exc_valid <= w_done & mmu_exc;
            r_exc_src   <= w_done & mmu_exc & (r_state == S_I_R);
            r_exc_vec   <= (w_done & mmu_exc) ? mmu_exc_vec : 3'b000;
        end
    end

    assign is_instr  = r_is_instr;
    assign exc_valid = r_exc_valid;
    assign exc_src   = r_exc_src;
    assign exc_vec   = r_exc_vec;

endmodule
`default_nettype wire

// File: tb/tb_mmu_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_port_arbiter
// Purpose  : Self-checking bench for mmu_port_arbiter (fixed-priority build):
//            grant table, directed corner sequences and randomized traffic
//            against a grant/starvation reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_port_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_araddr, d_araddr, d_awaddr, m_araddr, m_awaddr;
    logic          i_arvalid, i_arready, i_rvalid, i_rready;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_rdata, m_wdata;
    logic [1:0]    i_rresp, d_rresp, d_bresp, m_rresp, m_bresp;
    logic          d_arvalid, d_arready, d_rvalid, d_rready;
    logic          d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
    logic [3:0]    d_wstrb, m_wstrb;
    logic          m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic          m_wvalid, m_wready, m_bvalid, m_bready;
    logic          is_instr, mmu_exc, exc_valid, exc_src;
    logic [2:0]    mmu_exc_vec, exc_vec;

    mmu_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
        .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .is_instr(is_instr), .mmu_exc(mmu_exc), .mmu_exc_vec(mmu_exc_vec),
        .exc_valid(exc_valid), .exc_src(exc_src), .exc_vec(exc_vec)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state: data grants that overtook a waiting fetch
    int mdl_starve;

    bit            auto_req, force_mid_fetch;
    bit            fix_en;
    logic [DW-1:0] fix_rdata;
    logic          fix_exc;
    logic [2:0]    fix_vec;
    logic [DW-1:0] obs_rdata;
    logic          obs_exc_valid, obs_exc_src;
    logic [2:0]    obs_exc_vec;

    typedef struct {
        logic iv; logic dr; logic dw;
        logic exp_instr; logic exp_ar; logic exp_aw;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = fetch, 1 = data read, 2 = data write, 3 = nothing
    function automatic int model_pick(bit f, bit dr, bit dw);
        bit fetch_wins;
        fetch_wins = f && (!(dr || dw) || mdl_starve == STARVE);
        if (fetch_wins) return 0;
        if (dr) return 1;
        if (dw) return 2;
        return 3;
    endfunction

    function automatic void model_update(int g, bit f);
        if (g == 0 || (g < 3 && !f)) mdl_starve = 0;
        else if (g < 3 && mdl_starve < STARVE) mdl_starve = mdl_starve + 1;
    endfunction

    task automatic clear_inputs();
        i_araddr = '0; i_arvalid = 0; i_rready = 0;
        d_araddr = '0; d_arvalid = 0; d_rready = 0;
        d_awaddr = '0; d_awvalid = 0; d_wdata = '0; d_wstrb = '0; d_wvalid = 0; d_bready = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        mmu_exc = 0; mmu_exc_vec = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        rst = 0;
        mdl_starve = 0;
    endtask

    task automatic mid_fetch(input bit is_data);
        if (is_data && !i_arvalid && (force_mid_fetch || (auto_req && ($urandom % 2) == 1))) begin
            i_arvalid = 1;
            i_araddr  = $urandom;
        end
    endtask

    // Starts in IDLE at posedge+1, runs one whole transaction, ends in IDLE.
    task automatic do_round(output int g_obs);
        int            g_exp, dly;
        bit            sel;
        logic [DW-1:0] rd;
        logic [1:0]    rsp;
        logic          ex;
        logic [2:0]    ev;
        chk("idle_is_instr", is_instr, 0);
        if (auto_req) begin
            if (!i_arvalid && ($urandom % 4) != 0) begin
                i_arvalid = 1; i_araddr = $urandom;
            end
            if (!d_arvalid && !d_awvalid && ($urandom % 4) != 0) begin
                if (($urandom % 2) == 1) begin
                    d_arvalid = 1; d_araddr = $urandom;
                end else begin
                    d_awvalid = 1; d_awaddr = $urandom;
                    d_wvalid = 1; d_wdata = $urandom; d_wstrb = 4'($urandom);
                end
            end
            if (!i_arvalid && !d_arvalid && !d_awvalid) begin
                i_arvalid = 1; i_araddr = $urandom;
            end
        end
        g_exp = model_pick(i_arvalid, d_arvalid, d_awvalid);
        model_update(g_exp, i_arvalid);
        rd  = fix_en ? fix_rdata : $urandom;
        rsp = 2'($urandom);
        ex  = fix_en ? fix_exc : (($urandom % 4) == 0);
        ev  = fix_en ? fix_vec : 3'($urandom);
        #1;
        chk("idle_no_fwd", {m_arvalid, m_awvalid, m_wvalid, i_arready, d_arready, d_awready, d_wready}, 0);
        tick();
        g_obs = is_instr ? 0 : (m_arvalid ? 1 : (m_awvalid ? 2 : 3));
        chk("grant", g_obs, g_exp);
        chk("exc_pulse_end", exc_valid, 0);
        if (g_obs != g_exp) begin
            do_reset();
            return;
        end
        if (g_exp != 2) begin
            sel = (g_exp == 0);
            chk("araddr", m_araddr, sel ? i_araddr : d_araddr);
            chk("is_instr_ar", is_instr, sel);
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                chk("ar_wait_ready", {i_arready, d_arready}, 0);
                tick();
                chk("ar_hold_valid", m_arvalid, 1);
            end
            m_arready = 1;
            #1;
            chk("ar_ready_route", {i_arready, d_arready}, sel ? 2'b10 : 2'b01);
            tick();
            if (sel) i_arvalid = 0; else d_arvalid = 0;
            mid_fetch(!sel);
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                m_arready = 1'($urandom);
                #1;
                chk("r_wait_quiet", {m_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, m_rready}, 0);
                tick();
            end
            m_arready = 1'($urandom);
            m_rvalid = 1; m_rdata = rd; m_rresp = rsp; mmu_exc = ex; mmu_exc_vec = ev;
            if (sel) i_rready = 1; else d_rready = 1;
            #1;
            obs_rdata = sel ? i_rdata : d_rdata;
            chk("rdata", obs_rdata, rd);
            chk("rresp", sel ? i_rresp : d_rresp, rsp);
            chk("r_route", {i_rvalid, d_rvalid, m_rready, m_arvalid, i_arready, d_arready},
                sel ? 6'b101000 : 6'b011000);
            chk("is_instr_r", is_instr, sel);
            tick();
            m_rvalid = 0; i_rready = 0; d_rready = 0;
        end else begin
            sel = 0;
            chk("awaddr", m_awaddr, d_awaddr);
            chk("aw_no_w", {m_wvalid, d_wready, m_arvalid, is_instr}, 0);
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                chk("aw_wait_ready", d_awready, 0);
                tick();
            end
            m_awready = 1;
            #1;
            chk("aw_ready_route", {d_awready, i_arready, d_arready}, 3'b100);
            tick();
            m_awready = 0; d_awvalid = 0;
            mid_fetch(1);
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                m_arready = 1'($urandom);
                #1;
                chk("w_wait", {m_wvalid, d_wready, i_arready, m_awvalid, m_arvalid}, 5'b10000);
                tick();
            end
            m_wready = 1;
            #1;
            chk("wdata", m_wdata, d_wdata);
            chk("wstrb", m_wstrb, d_wstrb);
            chk("w_route", {d_wready, m_wvalid, i_arready}, 3'b110);
            tick();
            m_wready = 0; d_wvalid = 0;
            dly = $urandom_range(0, 2);
            repeat (dly) begin
                m_arready = 1'($urandom);
                #1;
                chk("b_wait", {d_bvalid, m_bready, i_arready, m_wvalid, m_arvalid}, 0);
                tick();
            end
            m_bvalid = 1; m_bresp = rsp; mmu_exc = ex; mmu_exc_vec = ev; d_bready = 1;
            #1;
            chk("bresp", d_bresp, rsp);
            chk("b_route", {d_bvalid, m_bready, i_arready, i_rvalid}, 4'b1100);
            tick();
            m_bvalid = 0; d_bready = 0;
        end
        mmu_exc = 0; m_arready = 0;
        obs_exc_valid = exc_valid; obs_exc_src = exc_src; obs_exc_vec = exc_vec;
        chk("exc_valid", exc_valid, ex);
        if (ex) begin
            chk("exc_src", exc_src, sel);
            chk("exc_vec", exc_vec, ev);
        end
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int g;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        auto_req = 0; force_mid_fetch = 0; fix_en = 0;
        fix_rdata = '0; fix_exc = 0; fix_vec = '0;
        mdl_starve = 0;

        // reset with busy inputs: nothing may be forwarded
        rst = 1;
        clear_inputs();
        i_arvalid = 1; d_arvalid = 1; d_awvalid = 1; d_wvalid = 1;
        m_arready = 1; m_rvalid = 1; m_awready = 1; m_wready = 1; m_bvalid = 1;
        i_rready = 1; d_rready = 1; d_bready = 1; mmu_exc = 1;
        repeat (2) tick();
        chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid, i_rvalid, d_rvalid, d_bvalid}, 0);
        chk("rst_readys", {i_arready, d_arready, d_awready, d_wready, m_rready, m_bready}, 0);
        chk("rst_flags", {is_instr, exc_valid, exc_src, exc_vec}, 0);
        chk("rst_data", {m_araddr, m_awaddr}, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            i_arvalid = tbl[i].iv; i_araddr = 32'h1000 + i;
            d_arvalid = tbl[i].dr; d_araddr = 32'h2000 + i;
            d_awvalid = tbl[i].dw; d_awaddr = 32'h3000 + i;
            #1;
            chk("tbl_idle", {m_arvalid, m_awvalid, is_instr}, 0);
            tick();
            chk("tbl_is_instr", is_instr, tbl[i].exp_instr);
            chk("tbl_arvalid", m_arvalid, tbl[i].exp_ar);
            chk("tbl_awvalid", m_awvalid, tbl[i].exp_aw);
            if (tbl[i].exp_ar)
                chk("tbl_araddr", m_araddr, tbl[i].exp_instr ? 32'h1000 + i : 32'h2000 + i);
            else
                chk("tbl_awaddr", m_awaddr, 32'h3000 + i);
        end

        // fetch only, with an MMU exception on the R handshake
        do_reset();
        i_arvalid = 1; i_araddr = 32'h100;
        fix_en = 1; fix_rdata = 32'hDEADBEEF; fix_exc = 1; fix_vec = 3'b001;
        do_round(g);
        fix_en = 0;
        chk("seq_fetch_grant", g, 0);
        chk("seq_fetch_rdata", obs_rdata, 32'hDEADBEEF);
        chk("seq_exc", {obs_exc_valid, obs_exc_src, obs_exc_vec}, 5'b11001);
        tick();
        chk("seq_exc_one_cycle", exc_valid, 0);

        // simultaneous fetch and data read
        do_reset();
        i_arvalid = 1; i_araddr = 32'h200; d_arvalid = 1; d_araddr = 32'h300;
        do_round(g);
        chk("seq_sim_first", g, 1);
        do_round(g);
        chk("seq_sim_second", g, 0);

        // data write with a fetch raised mid-transaction
        do_reset();
        d_awvalid = 1; d_awaddr = 32'h80000004;
        d_wvalid = 1; d_wdata = 32'h41000000; d_wstrb = 4'hF;
        force_mid_fetch = 1;
        do_round(g);
        force_mid_fetch = 0;
        chk("seq_wr_grant", g, 2);
        do_round(g);
        chk("seq_wr_then_fetch", g, 0);

        // fetch starvation limit
        do_reset();
        i_arvalid = 1; i_araddr = 32'h400;
        for (int k = 0; k < STARVE + 1; k++) begin
            d_arvalid = 1; d_araddr = 32'h500 + k;
            do_round(g);
            chk("seq_starve_grant", g, (k < STARVE) ? 1 : 0);
        end

        // reset while in D_W, then a clean fetch
        do_reset();
        d_awvalid = 1; d_awaddr = 32'h600; d_wvalid = 1; d_wdata = 32'h12345678; d_wstrb = 4'h3;
        tick();
        m_awready = 1;
        tick();
        m_awready = 0; d_awvalid = 0; m_wready = 1;
        #1;
        chk("rst_dw_pre", {m_wvalid, d_wready}, 2'b11);
        rst = 1;
        tick();
        chk("rst_dw_wvalid", m_wvalid, 0);
        chk("rst_dw_wready", d_wready, 0);
        rst = 0; d_wvalid = 0; m_wready = 0; mdl_starve = 0;
        i_arvalid = 1; i_araddr = 32'h700;
        do_round(g);
        chk("rst_dw_fetch_after", g, 0);

        // randomized traffic against the model
        do_reset();
        auto_req = 1;
        repeat (200) do_round(g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
